branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Parametrised successor to the EX-stage branch decision logic: resolves conditional branches and adds dynamic prediction.
//  IF side: BTB (target cache) + BHT (saturating counters) give a predicted next PC in the same cycle (combinational read).
//  EX side: evaluates BranchTypeE on two operands, compares the outcome with the prediction carried down the pipe,
//  raises a flush/redirect on mispredict, updates the tables one clock later, and keeps performance counters.
// PARAMETERS
//  XLEN         32   operand / PC width
//  BTB_ENTRIES  64   direct-mapped BTB entries, power of 2
//  BHT_ENTRIES  256  BHT counters, power of 2, >= BTB_ENTRIES
//  CNT_BITS     2    saturating counter width; predict taken when MSB=1
//  PERF_BITS    32   width of performance counters
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          synchronous, active-low reset
//  pc_f           in   XLEN       fetch PC
//  pred_taken_f   out  1          predicted taken (BTB hit AND counter MSB)
//  pred_target_f  out  XLEN       next PC: BTB target if pred_taken_f, else pc_f+4
//  valid_e        in   1          EX holds a valid instruction
//  stall_e        in   1          EX frozen this cycle; no resolve, no update
//  pc_e           in   XLEN       PC of EX instruction
//  BranchTypeE    in   3          NOBRANCH/BEQ/BNE/BLT/BLTU/BGE/BGEU (shared encoding 0..6)
//  Operand1/2     in   XLEN       compare operands (rs1, rs2 after forwarding)
//  br_target_e    in   XLEN       computed target (pc_e + imm)
//  pred_taken_e   in   1          pred_taken_f carried down to EX
//  pred_target_e  in   XLEN       pred_target_f carried down to EX
//  BranchE        out  1          actual outcome; 0 for NOBRANCH/invalid/unused codes
//  mispredict_e   out  1          flush IF/ID, redirect fetch
//  redirect_pc_e  out  XLEN       BranchE ? br_target_e : pc_e+4
//  perf_branches  out  PERF_BITS  resolved conditional branches
//  perf_mispred   out  PERF_BITS  mispredicted branches
// BEHAVIOUR
//  - Index: btb_idx = pc[log2(BTB_ENTRIES)+1:2]; bht_idx = pc[log2(BHT_ENTRIES)+1:2]; tag = remaining high PC bits.
//  - Compare: signed (BLT/BGE) via $signed, unsigned (BLTU/BGEU) full XLEN; codes 7 and NOBRANCH -> BranchE=0.
//  - resolve = valid_e & ~stall_e & (BranchTypeE in BEQ..BGEU).
//  - mispredict_e = resolve & (BranchE != pred_taken_e | (BranchE & pred_target_e != br_target_e)); 0 when not resolve.
//  - BranchE, mispredict_e, redirect_pc_e are combinational (0-cycle latency within EX).
//  - Update on clk edge when resolve: BHT[bht_idx] +1 if taken (saturate at all-ones), -1 if not (saturate at 0).
//    If taken: BTB[btb_idx] <= {valid=1, tag, br_target_e} (overwrite on conflict). Not taken: BTB untouched.
//  - Read/write same entry in one cycle: IF read returns pre-update (old) value; new value visible next cycle.
//  - Perf: perf_branches +1 per resolve; perf_mispred +1 per mispredict_e; both wrap modulo 2^PERF_BITS.
//  - Reset (rst_n=0 at edge): all BTB valid=0, all BHT = weakly-not-taken (2^(CNT_BITS-1)-1, i.e. 01), perf = 0.
//    After reset pred_taken_f=0, pred_target_f=pc_f+4. Reset takes priority over a simultaneous update.
//  - Combinational outputs during reset follow their inputs; consumer gates them with its own reset.
// STRUCTURE
//  - Shared include: BranchType defines (NOBRANCH..BGEU), already in the common parameter header; add
//    BHT_INIT and clog2 helper there.
//  - One sub-module: branch_compare (pure combinational type/operand -> taken), reused in EX; tables,
//    update and perf counters stay in top.
// TESTING
//  - Reset then pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104; perf counters read 0.
//  - BEQ at pc_e=0x100, ops 5/5, target 0x200, pred 0 -> BranchE=1, mispredict=1, redirect 0x200;
//    next cycle pc_f=0x100 -> hit, counter 10, pred_taken_f=1, target 0x200.
//  - BLT 0xFFFFFFFF vs 1 -> taken; BLTU same ops -> not taken; BGE/BGEU mirrors; type 7 -> BranchE=0.
//  - Loop: same branch taken x4 then not taken -> counter saturates 11 then 10; last is mispredict, perf_mispred=2.
//  - Same-cycle IF read and EX update of index k -> IF sees old entry; stall_e=1 with valid branch -> no update, no count.
//  - Aliasing: 0x100 and 0x100+4*BTB_ENTRIES both taken -> second overwrites tag; first then misses (pred 0).

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-type encoding and table-sizing helpers for the branch prediction unit.
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BEQ      = 3'd1,
        BNE      = 3'd2,
        BLT      = 3'd3,
        BLTU     = 3'd4,
        BGE      = 3'd5,
        BGEU     = 3'd6
    } branch_type_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    // Weakly-not-taken: MSB clear, every lower bit set.
    function automatic int bht_init(input int cnt_bits);
        return (1 << (cnt_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Pure combinational branch condition evaluation: branch type and two operands in, taken out.
module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            taken
);

    logic signed [XLEN-1:0] signed1;
    logic signed [XLEN-1:0] signed2;
    branch_type_t           kind;

    assign signed1 = $signed(operand1);
    assign signed2 = $signed(operand2);
    assign kind    = branch_type_t'(branch_type);

    // Code 7 is unused and falls through to not-taken along with NOBRANCH.
    always_comb begin
        taken = 1'b0;
        case (kind)
            BEQ:     taken = (operand1 == operand2);
            BNE:     taken = (operand1 != operand2);
            BLT:     taken = (signed1 < signed2);
            BLTU:    taken = (operand1 < operand2);
            BGE:     taken = (signed1 >= signed2);
            BGEU:    taken = (operand1 >= operand2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: BTB + BHT lookup at fetch, branch resolution, table update and
// performance counting at execute.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256,
    parameter int CNT_BITS    = 2,
    parameter int PERF_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      pc_f,
    output logic                 pred_taken_f,
    output logic [XLEN-1:0]      pred_target_f,
    input  logic                 valid_e,
    input  logic                 stall_e,
    input  logic [XLEN-1:0]      pc_e,
    input  logic [2:0]           BranchTypeE,
    input  logic [XLEN-1:0]      Operand1,
    input  logic [XLEN-1:0]      Operand2,
    input  logic [XLEN-1:0]      br_target_e,
    input  logic                 pred_taken_e,
    input  logic [XLEN-1:0]      pred_target_e,
    output logic                 BranchE,
    output logic                 mispredict_e,
    output logic [XLEN-1:0]      redirect_pc_e,
    output logic [PERF_BITS-1:0] perf_branches,
    output logic [PERF_BITS-1:0] perf_mispred
);

    localparam int BTB_IW = clog2(BTB_ENTRIES);
    localparam int BHT_IW = clog2(BHT_ENTRIES);
    localparam int TAG_W  = XLEN - BTB_IW - 2;
    localparam logic [CNT_BITS-1:0] BHT_INIT = CNT_BITS'(bht_init(CNT_BITS));

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_BITS'(1);
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - CNT_BITS'(1);
    endfunction

    logic                btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_target [BTB_ENTRIES];
    logic [CNT_BITS-1:0] bht        [BHT_ENTRIES];

    // Fetch-side lookup: reads the current (pre-update) table contents.
    logic [BTB_IW-1:0] btb_idx_f;
    logic [BHT_IW-1:0] bht_idx_f;
    logic [TAG_W-1:0]  tag_f;
    logic              hit_f;

    assign btb_idx_f     = pc_f[BTB_IW+1:2];
    assign bht_idx_f     = pc_f[BHT_IW+1:2];
    assign tag_f         = pc_f[XLEN-1:BTB_IW+2];
    assign hit_f         = btb_valid[btb_idx_f] && (btb_tag[btb_idx_f] == tag_f);
    assign pred_taken_f  = hit_f && bht[bht_idx_f][CNT_BITS-1];
    assign pred_target_f = pred_taken_f ? btb_target[btb_idx_f] : pc_f + XLEN'(4);

    // Execute-side resolution.
    logic [BTB_IW-1:0] btb_idx_e;
    logic [BHT_IW-1:0] bht_idx_e;
    logic [TAG_W-1:0]  tag_e;
    logic              cmp_taken;
    logic              is_cond;
    logic              resolve;

    branch_compare #(
        .XLEN(XLEN)
    ) u_branch_compare (
        .branch_type(BranchTypeE),
        .operand1   (Operand1),
        .operand2   (Operand2),
        .taken      (cmp_taken)
    );

    assign btb_idx_e     = pc_e[BTB_IW+1:2];
    assign bht_idx_e     = pc_e[BHT_IW+1:2];
    assign tag_e         = pc_e[XLEN-1:BTB_IW+2];
    assign is_cond       = (BranchTypeE >= 3'(BEQ)) && (BranchTypeE <= 3'(BGEU));
    assign resolve       = valid_e && !stall_e && is_cond;
    assign BranchE       = valid_e && cmp_taken;
    assign mispredict_e  = resolve && ((BranchE != pred_taken_e) ||
                                       (BranchE && (pred_target_e != br_target_e)));
    assign redirect_pc_e = BranchE ? br_target_e : pc_e + XLEN'(4);

    // Control state: valid bits, counters and perf counters; reset wins over an update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= BHT_INIT;
            end
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (resolve) begin
            bht[bht_idx_e] <= BranchE ? sat_inc(bht[bht_idx_e]) : sat_dec(bht[bht_idx_e]);
            if (BranchE) begin
                btb_valid[btb_idx_e] <= 1'b1;
            end
            perf_branches <= perf_branches + PERF_BITS'(1);
            if (mispredict_e) begin
                perf_mispred <= perf_mispred + PERF_BITS'(1);
            end
        end
    end

    // Tag/target payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (resolve && BranchE) begin
            btb_tag[btb_idx_e]    <= tag_e;
            btb_target[btb_idx_e] <= br_target_e;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        valid_e;
    logic        stall_e;
    logic [31:0] pc_e;
    logic [2:0]  BranchTypeE;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] br_target_e;
    logic        pred_taken_e;
    logic [31:0] pred_target_e;
    logic        BranchE;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;

    int tests_run = 0;
    int failures  = 0;

    branch_predict_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_f         (pc_f),
        .pred_taken_f (pred_taken_f),
        .pred_target_f(pred_target_f),
        .valid_e      (valid_e),
        .stall_e      (stall_e),
        .pc_e         (pc_e),
        .BranchTypeE  (BranchTypeE),
        .Operand1     (Operand1),
        .Operand2     (Operand2),
        .br_target_e  (br_target_e),
        .pred_taken_e (pred_taken_e),
        .pred_target_e(pred_target_e),
        .BranchE      (BranchE),
        .mispredict_e (mispredict_e),
        .redirect_pc_e(redirect_pc_e),
        .perf_branches(perf_branches),
        .perf_mispred (perf_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_e       = 1'b0;
        stall_e       = 1'b0;
        pc_e          = 32'h0;
        BranchTypeE   = 3'd0;
        Operand1      = 32'h0;
        Operand2      = 32'h0;
        br_target_e   = 32'h0;
        pred_taken_e  = 1'b0;
        pred_target_e = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        pc_f = 32'h100;
        do_reset();
        #1;
        tests_run++;
        if (pred_taken_f !== 1'b0) begin
            failures++; $display("FAIL reset_pred_taken got %0b expected 0", pred_taken_f);
        end
        tests_run++;
        if (pred_target_f !== 32'h104) begin
            failures++; $display("FAIL reset_pred_target got %h expected 00000104", pred_target_f);
        end
        tests_run++;
        if (perf_branches !== 32'h0) begin
            failures++; $display("FAIL reset_perf_branches got %0d expected 0", perf_branches);
        end
        tests_run++;
        if (perf_mispred !== 32'h0) begin
            failures++; $display("FAIL reset_perf_mispred got %0d expected 0", perf_mispred);
        end
    endtask

    task automatic test_beq_first();
        valid_e       = 1'b1;
        pc_e          = 32'h100;
        BranchTypeE   = 3'd1;
        Operand1      = 32'd5;
        Operand2      = 32'd5;
        br_target_e   = 32'h200;
        pred_taken_e  = 1'b0;
        pred_target_e = 32'h104;
        pc_f          = 32'h100;
        #1;
        tests_run++;
        if (BranchE !== 1'b1) begin
            failures++; $display("FAIL beq_branch got %0b expected 1", BranchE);
        end
        tests_run++;
        if (mispredict_e !== 1'b1) begin
            failures++; $display("FAIL beq_mispredict got %0b expected 1", mispredict_e);
        end
        tests_run++;
        if (redirect_pc_e !== 32'h200) begin
            failures++; $display("FAIL beq_redirect got %h expected 00000200", redirect_pc_e);
        end
        // Same-cycle read of the entry being written sees the old contents.
        tests_run++;
        if (pred_taken_f !== 1'b0) begin
            failures++; $display("FAIL same_cycle_old_pred got %0b expected 0", pred_taken_f);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (pred_taken_f !== 1'b1) begin
            failures++; $display("FAIL beq_next_pred got %0b expected 1", pred_taken_f);
        end
        tests_run++;
        if (pred_target_f !== 32'h200) begin
            failures++; $display("FAIL beq_next_target got %h expected 00000200", pred_target_f);
        end
        tests_run++;
        if (perf_branches !== 32'd1) begin
            failures++; $display("FAIL beq_perf_branches got %0d expected 1", perf_branches);
        end
        tests_run++;
        if (perf_mispred !== 32'd1) begin
            failures++; $display("FAIL beq_perf_mispred got %0d expected 1", perf_mispred);
        end
    endtask

    task automatic test_compare();
        logic [2:0]  vtype [10];
        logic [31:0] va    [10];
        logic [31:0] vb    [10];
        logic        vexp  [10];
        vtype[0] = 3'd3; va[0] = 32'hFFFFFFFF; vb[0] = 32'd1;          vexp[0] = 1'b1;
        vtype[1] = 3'd4; va[1] = 32'hFFFFFFFF; vb[1] = 32'd1;          vexp[1] = 1'b0;
        vtype[2] = 3'd5; va[2] = 32'hFFFFFFFF; vb[2] = 32'd1;          vexp[2] = 1'b0;
        vtype[3] = 3'd6; va[3] = 32'hFFFFFFFF; vb[3] = 32'd1;          vexp[3] = 1'b1;
        vtype[4] = 3'd5; va[4] = 32'd1;        vb[4] = 32'hFFFFFFFF;   vexp[4] = 1'b1;
        vtype[5] = 3'd7; va[5] = 32'd5;        vb[5] = 32'd5;          vexp[5] = 1'b0;
        vtype[6] = 3'd0; va[6] = 32'd5;        vb[6] = 32'd5;          vexp[6] = 1'b0;
        vtype[7] = 3'd2; va[7] = 32'd5;        vb[7] = 32'd5;          vexp[7] = 1'b0;
        vtype[8] = 3'd2; va[8] = 32'd5;        vb[8] = 32'd6;          vexp[8] = 1'b1;
        vtype[9] = 3'd1; va[9] = 32'd5;        vb[9] = 32'd6;          vexp[9] = 1'b0;
        valid_e       = 1'b1;
        stall_e       = 1'b1;
        pc_e          = 32'h100;
        pc_f          = 32'h100;
        br_target_e   = 32'h200;
        pred_taken_e  = 1'b1;
        pred_target_e = 32'h999;
        for (int i = 0; i < 10; i++) begin
            BranchTypeE = vtype[i];
            Operand1    = va[i];
            Operand2    = vb[i];
            #1;
            tests_run++;
            if (BranchE !== vexp[i]) begin
                failures++; $display("FAIL cmp_branch[%0d] got %0b expected %0b", i, BranchE, vexp[i]);
            end
            tests_run++;
            if (redirect_pc_e !== (vexp[i] ? 32'h200 : 32'h104)) begin
                failures++; $display("FAIL cmp_redirect[%0d] got %h expected %h", i, redirect_pc_e,
                                     vexp[i] ? 32'h200 : 32'h104);
            end
            tests_run++;
            if (mispredict_e !== 1'b0) begin
                failures++; $display("FAIL cmp_stall_mispredict[%0d] got %0b expected 0", i, mispredict_e);
            end
        end
        // A stalled not-taken BEQ crosses an edge: counter and perf must stay put.
        tick();
        valid_e     = 1'b0;
        stall_e     = 1'b0;
        BranchTypeE = 3'd1;
        Operand1    = 32'd7;
        Operand2    = 32'd7;
        #1;
        tests_run++;
        if (BranchE !== 1'b0) begin
            failures++; $display("FAIL invalid_branch got %0b expected 0", BranchE);
        end
        tests_run++;
        if (perf_branches !== 32'd1) begin
            failures++; $display("FAIL stall_perf_branches got %0d expected 1", perf_branches);
        end
        tests_run++;
        if (perf_mispred !== 32'd1) begin
            failures++; $display("FAIL stall_perf_mispred got %0d expected 1", perf_mispred);
        end
        tests_run++;
        if (pred_taken_f !== 1'b1) begin
            failures++; $display("FAIL stall_no_update got %0b expected 1", pred_taken_f);
        end
        idle();
    endtask

    task automatic test_loop();
        logic exp_pred [6];
        logic taken    [6];
        logic exp_misp [6];
        exp_pred = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        taken    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_misp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        idle();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            valid_e       = 1'b1;
            pc_e          = 32'h140;
            pc_f          = 32'h140;
            BranchTypeE   = 3'd1;
            Operand1      = 32'd7;
            Operand2      = taken[i] ? 32'd7 : 32'd8;
            br_target_e   = 32'h180;
            pred_taken_e  = exp_pred[i];
            pred_target_e = exp_pred[i] ? 32'h180 : 32'h144;
            #1;
            tests_run++;
            if (pred_taken_f !== exp_pred[i]) begin
                failures++; $display("FAIL loop_pred[%0d] got %0b expected %0b", i, pred_taken_f, exp_pred[i]);
            end
            tests_run++;
            if (pred_target_f !== (exp_pred[i] ? 32'h180 : 32'h144)) begin
                failures++; $display("FAIL loop_target[%0d] got %h expected %h", i, pred_target_f,
                                     exp_pred[i] ? 32'h180 : 32'h144);
            end
            tests_run++;
            if (mispredict_e !== exp_misp[i]) begin
                failures++; $display("FAIL loop_mispredict[%0d] got %0b expected %0b", i, mispredict_e, exp_misp[i]);
            end
            tick();
            if (i == 4) begin
                tests_run++;
                if (perf_branches !== 32'd5) begin
                    failures++; $display("FAIL loop_perf_branches got %0d expected 5", perf_branches);
                end
                tests_run++;
                if (perf_mispred !== 32'd2) begin
                    failures++; $display("FAIL loop_perf_mispred got %0d expected 2", perf_mispred);
                end
            end
        end
        idle();
        #1;
        tests_run++;
        if (pred_taken_f !== 1'b0) begin
            failures++; $display("FAIL loop_final_pred got %0b expected 0", pred_taken_f);
        end
        tests_run++;
        if (pred_target_f !== 32'h144) begin
            failures++; $display("FAIL loop_final_target got %h expected 00000144", pred_target_f);
        end
    endtask

    task automatic resolve_taken(input logic [31:0] pc, input logic [31:0] target);
        valid_e       = 1'b1;
        pc_e          = pc;
        BranchTypeE   = 3'd1;
        Operand1      = 32'd3;
        Operand2      = 32'd3;
        br_target_e   = target;
        pred_taken_e  = 1'b0;
        pred_target_e = pc + 32'd4;
        tick();
        idle();
    endtask

    task automatic test_alias();
        // Reset asserted while a taken branch resolves: reset must win.
        idle();
        rst_n         = 1'b0;
        valid_e       = 1'b1;
        pc_e          = 32'h100;
        BranchTypeE   = 3'd1;
        Operand1      = 32'd3;
        Operand2      = 32'd3;
        br_target_e   = 32'h300;
        tick();
        rst_n = 1'b1;
        idle();
        pc_f = 32'h100;
        #1;
        tests_run++;
        if (perf_branches !== 32'd0) begin
            failures++; $display("FAIL rst_priority_perf got %0d expected 0", perf_branches);
        end
        tests_run++;
        if (pred_taken_f !== 1'b0) begin
            failures++; $display("FAIL rst_priority_pred got %0b expected 0", pred_taken_f);
        end
        resolve_taken(32'h100, 32'h300);
        pc_f = 32'h100;
        #1;
        tests_run++;
        if (pred_target_f !== 32'h300) begin
            failures++; $display("FAIL alias_first_target got %h expected 00000300", pred_target_f);
        end
        resolve_taken(32'h200, 32'h400);
        pc_f = 32'h100;
        #1;
        tests_run++;
        if (pred_taken_f !== 1'b0) begin
            failures++; $display("FAIL alias_first_miss got %0b expected 0", pred_taken_f);
        end
        tests_run++;
        if (pred_target_f !== 32'h104) begin
            failures++; $display("FAIL alias_first_fallthrough got %h expected 00000104", pred_target_f);
        end
        pc_f = 32'h200;
        #1;
        tests_run++;
        if (pred_taken_f !== 1'b1) begin
            failures++; $display("FAIL alias_second_hit got %0b expected 1", pred_taken_f);
        end
        tests_run++;
        if (pred_target_f !== 32'h400) begin
            failures++; $display("FAIL alias_second_target got %h expected 00000400", pred_target_f);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pc_f  = 32'h0;
        idle();
        test_reset();
        test_beq_first();
        test_compare();
        test_loop();
        test_alias();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
